// File: rtl/ring_johnson_counter_if.sv
// ring_johnson_counter_if: control/status bundle for ring_johnson_counter.
// Rev 1.0 - initial release.
`default_nettype none

interface ring_johnson_counter_if #(
  parameter int WIDTH = 4
);
  logic             iEn;
  logic             iMode;
  logic             iDir;
  logic             iLoad;
  logic [WIDTH-1:0] iLoadVal;
  logic [WIDTH-1:0] oQ;
  logic             oWrap;
  logic             oErr;

  modport master (
    output iEn, iMode, iDir, iLoad, iLoadVal,
    input  oQ, oWrap, oErr
  );

  modport slave (
    input  iEn, iMode, iDir, iLoad, iLoadVal,
    output oQ, oWrap, oErr
  );
endinterface

`default_nettype wire

// File: rtl/ring_johnson_counter.sv
// ring_johnson_counter: one-hot ring / Johnson sequencer with prescaler, load and wrap pulse.
// Optional legality check: RING_JOHNSON_COUNTER_STATE_CHECK_EN. Rev 1.0 - initial release.
`default_nettype none

module ring_johnson_counter #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  wire logic              iClk,
  input  wire logic              iRst,
  ring_johnson_counter_if.slave  bus
);

  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PS_LAST  = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] SEED_R   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SEED_J   = '0;

  logic [WIDTH-1:0] r_q;
  logic             r_mode;
  logic [PW-1:0]    r_presc;
  logic             r_wrap;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_mode_nxt;
  logic [PW-1:0]    w_presc_nxt;
  logic             w_wrap_nxt;

  logic [WIDTH-1:0] w_seed_cur;
  logic [WIDTH-1:0] w_seed_new;
  logic             w_fb_fwd;
  logic             w_fb_rev;
  logic [WIDTH-1:0] w_step;

  assign w_seed_cur = r_mode    ? SEED_J : SEED_R;
  assign w_seed_new = bus.iMode ? SEED_J : SEED_R;

  // Johnson differs from ring only by inverting the bit fed back into the vacated end.
  assign w_fb_fwd = r_mode ? ~r_q[WIDTH-1] : r_q[WIDTH-1];
  assign w_fb_rev = r_mode ? ~r_q[0]       : r_q[0];
  assign w_step   = bus.iDir ? {w_fb_rev, r_q[WIDTH-1:1]}
                             : {r_q[WIDTH-2:0], w_fb_fwd};

`ifdef RING_JOHNSON_COUNTER_STATE_CHECK_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic          r_err;
  logic          w_err_nxt;
  logic          w_illegal;
  logic [CW-1:0] w_ones;
  logic [CW-1:0] w_edges;

  always_comb begin
    w_ones  = '0;
    w_edges = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ones = w_ones + CW'(r_q[i]);
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      w_edges = w_edges + CW'(r_q[i] ^ r_q[i+1]);
    end
    w_illegal = r_mode ? (w_edges > CW'(1)) : (w_ones != CW'(1));
  end
`endif

  always_comb begin
    w_q_nxt     = r_q;
    w_mode_nxt  = r_mode;
    w_presc_nxt = r_presc;
    w_wrap_nxt  = 1'b0;
`ifdef RING_JOHNSON_COUNTER_STATE_CHECK_EN
    w_err_nxt   = r_err;
`endif
    if (bus.iLoad) begin
      w_q_nxt     = bus.iLoadVal;
      w_presc_nxt = '0;
    end else if (bus.iMode != r_mode) begin
      w_q_nxt     = w_seed_new;
      w_mode_nxt  = bus.iMode;
      w_presc_nxt = '0;
`ifdef RING_JOHNSON_COUNTER_STATE_CHECK_EN
    end else if (w_illegal) begin
      w_q_nxt     = w_seed_cur;
      w_presc_nxt = '0;
      w_err_nxt   = 1'b1;
`endif
    end else if (bus.iEn) begin
      if (r_presc == PS_LAST) begin
        w_q_nxt     = w_step;
        w_presc_nxt = '0;
        w_wrap_nxt  = (w_step == w_seed_cur);
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_q     <= SEED_R;
      r_mode  <= 1'b0;
      r_presc <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_mode  <= w_mode_nxt;
      r_presc <= w_presc_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

`ifdef RING_JOHNSON_COUNTER_STATE_CHECK_EN
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
    end
  end

  assign bus.oErr = r_err;
`else
  assign bus.oErr = 1'b0;
`endif

  assign bus.oQ    = r_q;
  assign bus.oWrap = r_wrap;

endmodule

`default_nettype wire
